room_thermal_model: RTL and testbench
=====================================

Name: room_thermal_model

Overview:
Behavioural-but-synthesisable plant model for the other end of the Smart_Home thermostat interface. It consumes the controller's heating/cooling outputs and generates the 5-bit temperature the controller reads, closing the loop for system-level benches and FPGA demos. Temperature ramps under heating/cooling, drifts toward an ambient setpoint when idle, and freezes with a fault flag on contradictory drive.

Parameters:
INIT_TEMP, 18, temperature value loaded on reset (0..31)
STEP_CYCLES, 4, clock cycles per 1-degree step while heating or cooling (>=1)
DRIFT_CYCLES, 16, clock cycles per 1-degree step toward ambient while idle (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
heating  input  1  heater drive from controller
cooling  input  1  cooler drive from controller
ambient  input  5  unsigned ambient temperature the room drifts toward
temperature  output  5  current room temperature, unsigned, registered
temp_valid  output  1  one-cycle pulse on the cycle temperature takes a new value
fault  output  1  high while in FAULT state
fault_seen  output  1  sticky; set on any FAULT entry, cleared only by rst

Behaviour:
- rst sampled high at an edge: temperature=INIT_TEMP, state=IDLE, step counter=0, temp_valid=0, fault=0, fault_seen=0. Reset mid-ramp discards the partial count.
- State register (2 bits), next state from the inputs sampled at the same edge:
  - heating=0, cooling=0 -> IDLE
  - heating=1, cooling=0 -> HEAT
  - heating=0, cooling=1 -> COOL
  - heating=1, cooling=1 -> FAULT
  Transitions are legal between any pair in one cycle.
- Step counter width = clog2(max(STEP_CYCLES, DRIFT_CYCLES)).
  - On any edge where next state != current state: counter <= 0, no temperature change on that edge.
  - Otherwise the counter increments.
  - At the terminal count (HEAT/COOL: STEP_CYCLES-1; IDLE: DRIFT_CYCLES-1) the counter wraps to 0 and a step is applied on that edge.
  - Inputs first seen at edge N give the first step at edge N+STEP_CYCLES (or N+DRIFT_CYCLES in IDLE).
- Step actions:
  - HEAT: temperature+1, saturating at 31.
  - COOL: temperature-1, saturating at 0.
  - IDLE: temperature moves 1 toward ambient. No change if temperature==ambient. ambient is sampled at the step edge only.
  - FAULT: never steps. Temperature is held. The counter is held at 0.
- Saturation or idle equality: the counter keeps running, but temperature is unchanged and temp_valid stays 0.
- temp_valid: registered, high for exactly the one cycle after the edge on which temperature changed value. Never high coincident with reset.
- fault: equals (state==FAULT), registered with state.
  - fault_seen: set on the edge entering FAULT. Stays set through later exits.
- Arithmetic is unsigned 5-bit with explicit saturation; no wrap-around 31->0 or 0->31 is permitted.

Test Plan:
- Reset value: INIT_TEMP=18, rst held 2 cycles then released, heating=cooling=0, ambient=18 -> temperature=18, temp_valid never pulses over 100 cycles, fault=fault_seen=0.
- Heat ramp: from 18, heating=1 at edge N -> temperature 19 at edge N+4, 20 at N+8. Exactly one temp_valid pulse per step.
- Heat saturation: heating=1 for 80 cycles from 18 -> reaches 31 at edge N+52, then stays 31 with no further temp_valid. Cooling from 0 likewise stays at 0.
- Idle drift: temperature=24, ambient=20, inputs idle -> 23 at +16 cycles, then 22, 21, 20, then holds at 20. Changing ambient to 22 mid-count takes effect at the next step edge.
- Fault/state restart:
  - heating=cooling=1 for 10 cycles from 20 -> temperature frozen at 20, fault=1 for 10 cycles, fault_seen=1 thereafter.
  - Release to cooling only -> 19 at 4 cycles after the transition edge.
  - Toggling heating every 3 cycles with STEP_CYCLES=4 produces no temperature change.
- Reset mid-operation: rst at count 2 of a HEAT ramp from 25 -> temperature=18, counter=0, fault_seen cleared, with rst released and heating still high.
  - Required response: next step to 19 lands 4 edges after the release edge.

Source files
------------

// File: rtl/room_thermal_model.sv
// Room temperature plant model: ramps under heating/cooling, drifts toward ambient when idle,
// and freezes with a fault flag when heating and cooling are driven together.
module room_thermal_model #(
   parameter int INIT_TEMP    = 18,
   parameter int STEP_CYCLES  = 4,
   parameter int DRIFT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       heating,
   input  logic       cooling,
   input  logic [4:0] ambient,
   output logic [4:0] temperature,
   output logic       temp_valid,
   output logic       fault,
   output logic       fault_seen
);

   localparam int MAX_CYC = (STEP_CYCLES > DRIFT_CYCLES) ? STEP_CYCLES : DRIFT_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] STEP_TC  = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRIFT_TC = CNT_W'(DRIFT_CYCLES - 1);
   localparam logic [4:0]       INIT_T   = 5'(INIT_TEMP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HEAT  = 2'd1,
      S_COOL  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] term_cnt;
   logic [4:0]       temp_q, temp_d;
   logic             valid_q, valid_d;
   logic             fault_seen_q, fault_seen_d;
   logic             step_en;

   always_comb begin
      state_d = S_IDLE;
      case ({heating, cooling})
         2'b00:   state_d = S_IDLE;
         2'b10:   state_d = S_HEAT;
         2'b01:   state_d = S_COOL;
         default: state_d = S_FAULT;
      endcase
   end

   // Any state change (and FAULT itself) restarts the step interval from zero.
   always_comb begin
      term_cnt = (state_q == S_IDLE) ? DRIFT_TC : STEP_TC;
      step_en  = 1'b0;
      cnt_d    = cnt_q;
      if (state_d != state_q || state_q == S_FAULT) begin
         cnt_d = '0;
      end else if (cnt_q == term_cnt) begin
         cnt_d   = '0;
         step_en = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      temp_d = temp_q;
      if (step_en) begin
         case (state_q)
            S_HEAT:  if (temp_q != 5'd31) temp_d = temp_q + 5'd1;
            S_COOL:  if (temp_q != 5'd0)  temp_d = temp_q - 5'd1;
            S_IDLE: begin
               if (temp_q > ambient)      temp_d = temp_q - 5'd1;
               else if (temp_q < ambient) temp_d = temp_q + 5'd1;
            end
            default: temp_d = temp_q;
         endcase
      end
      valid_d      = (temp_d != temp_q);
      fault_seen_d = fault_seen_q | (state_d == S_FAULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         temp_q       <= INIT_T;
         valid_q      <= 1'b0;
         fault_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         temp_q       <= temp_d;
         valid_q      <= valid_d;
         fault_seen_q <= fault_seen_d;
      end
   end

   assign temperature = temp_q;
   assign temp_valid  = valid_q;
   assign fault       = (state_q == S_FAULT);
   assign fault_seen  = fault_seen_q;

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model: a vector table of multi-cycle phases plus
// hand-timed sequences for step latency, idle drift, state toggling and mid-ramp reset.
module tb_room_thermal_model;

   logic       clk = 1'b0;
   logic       rst;
   logic       heating;
   logic       cooling;
   logic [4:0] ambient;
   logic [4:0] temperature;
   logic       temp_valid;
   logic       fault;
   logic       fault_seen;

   int checks = 0;
   int errors = 0;

   room_thermal_model #(
      .INIT_TEMP   (18),
      .STEP_CYCLES (4),
      .DRIFT_CYCLES(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .heating    (heating),
      .cooling    (cooling),
      .ambient    (ambient),
      .temperature(temperature),
      .temp_valid (temp_valid),
      .fault      (fault),
      .fault_seen (fault_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      int heat;
      int cool;
      int amb;
      int cycles;
      int exp_temp;
      int exp_pulses;
      int exp_fault;
      int exp_seen;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance n edges, sampling 1ns after each edge; returns temp_valid pulse count.
   task automatic run(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         pulses += int'(temp_valid);
      end
   endtask

   task automatic do_reset();
      int p;
      rst = 1'b1; heating = 1'b0; cooling = 1'b0; ambient = 5'd18;
      run(2, p);
      rst = 1'b0;
   endtask

   initial begin
      int p;
      // Phases run back to back from reset (temp 18).
      vecs[0]  = '{0, 0, 18, 100, 18,  0, 0, 0};  // idle at ambient: nothing moves
      vecs[1]  = '{1, 0, 18,   9, 20,  2, 0, 0};  // steps at N+4, N+8
      vecs[2]  = '{1, 0, 18,  80, 31, 11, 0, 0};  // saturate at 31
      vecs[3]  = '{0, 1, 18, 200,  0, 31, 0, 0};  // cool all the way down
      vecs[4]  = '{0, 1, 18,  40,  0,  0, 0, 0};  // saturate at 0
      vecs[5]  = '{0, 0,  5,  16,  0,  0, 0, 0};  // drift not yet due
      vecs[6]  = '{0, 0,  5,   1,  1,  1, 0, 0};  // drift lands at E+16
      vecs[7]  = '{0, 0,  5,  64,  5,  4, 0, 0};
      vecs[8]  = '{0, 0,  5,  32,  5,  0, 0, 0};  // equal to ambient: hold
      vecs[9]  = '{1, 1,  5,  10,  5,  0, 1, 1};  // fault freezes temperature
      vecs[10] = '{0, 1,  5,   5,  4,  1, 0, 1};  // restart cooling, sticky fault_seen

      rst = 1'b1; heating = 1'b0; cooling = 1'b0; ambient = 5'd18;
      run(2, p);
      check("reset_temp", int'(temperature), 18);
      check("reset_valid", p, 0);
      check("reset_fault", int'(fault), 0);
      check("reset_seen", int'(fault_seen), 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         heating = 1'(vecs[i].heat);
         cooling = 1'(vecs[i].cool);
         ambient = 5'(vecs[i].amb);
         run(vecs[i].cycles, p);
         check($sformatf("vec%0d_temp", i), int'(temperature), vecs[i].exp_temp);
         check($sformatf("vec%0d_pulses", i), p, vecs[i].exp_pulses);
         check($sformatf("vec%0d_fault", i), int'(fault), vecs[i].exp_fault);
         check($sformatf("vec%0d_seen", i), int'(fault_seen), vecs[i].exp_seen);
      end

      // Heat ramp edge timing: step on edge N+4, valid for exactly one cycle.
      do_reset();
      heating = 1'b1;
      run(4, p);
      check("ramp_pre_temp", int'(temperature), 18);
      check("ramp_pre_pulses", p, 0);
      run(1, p);
      check("ramp_step1_temp", int'(temperature), 19);
      check("ramp_step1_valid", int'(temp_valid), 1);
      run(1, p);
      check("ramp_valid_drop", int'(temp_valid), 0);
      run(3, p);
      check("ramp_step2_temp", int'(temperature), 20);
      check("ramp_step2_pulses", p, 1);

      // Idle drift from 24 toward 20, then ambient moved mid-count.
      do_reset();
      heating = 1'b1;
      run(25, p);
      check("drift_setup_temp", int'(temperature), 24);
      heating = 1'b0; ambient = 5'd20;
      run(16, p);
      check("drift_pre_temp", int'(temperature), 24);
      run(1, p);
      check("drift_step1_temp", int'(temperature), 23);
      run(8, p);
      ambient = 5'd26;
      run(8, p);
      check("drift_amb_change_temp", int'(temperature), 24);
      check("drift_amb_change_pulses", p, 1);
      ambient = 5'd24;
      run(40, p);
      check("drift_hold_temp", int'(temperature), 24);
      check("drift_hold_pulses", p, 0);

      // Toggling heating every 3 cycles never completes a 4-cycle step.
      do_reset();
      begin
         int tot = 0;
         for (int k = 0; k < 10; k++) begin
            heating = ~heating;
            run(3, p);
            tot += p;
         end
         check("toggle_temp", int'(temperature), 18);
         check("toggle_pulses", tot, 0);
      end

      // Reset in the middle of a HEAT ramp, with fault_seen previously set.
      do_reset();
      heating = 1'b1; cooling = 1'b1;
      run(2, p);
      check("mid_fault_seen", int'(fault_seen), 1);
      cooling = 1'b0;
      run(29, p);
      check("mid_setup_temp", int'(temperature), 25);
      run(2, p);
      rst = 1'b1;
      run(1, p);
      check("mid_rst_temp", int'(temperature), 18);
      check("mid_rst_valid", int'(temp_valid), 0);
      check("mid_rst_seen", int'(fault_seen), 0);
      check("mid_rst_fault", int'(fault), 0);
      rst = 1'b0;
      run(4, p);
      check("mid_release_pre_temp", int'(temperature), 18);
      run(1, p);
      check("mid_release_step_temp", int'(temperature), 19);
      check("mid_release_step_valid", int'(temp_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
